// File: rtl/snax_gemm_csr_sequencer.sv
// -----------------------------------------------------------------------------
// snax_gemm_csr_sequencer
//
// Hardware launcher for the streamer-GEMM accelerator. A shadow bank holds the
// configuration CSR values. On a launch command the block drives the
// accelerator's CSR request/response port with no core involvement. It writes
// every configuration CSR in index order, then writes the start CSR. It then
// polls the status CSR, with PollGap idle cycles between reads, until the busy
// bits clear or MaxPolls reads have been made.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cfg_wr_*                 shadow write port (valid/ready, index, data)
//   launch_valid_i/ready_o   launch handshake
//   busy_o                   sequence in progress
//   done_o                   one-cycle completion pulse
//   error_o                  sticky poll-timeout flag, cleared by the next launch
//   csr_req_*                CSR request towards the accelerator
//   csr_rsp_*                CSR read response from the accelerator
// -----------------------------------------------------------------------------
module snax_gemm_csr_sequencer #(
  parameter int unsigned NumCfgCsr     = 16,
  parameter logic [31:0] CfgBaseAddr   = 32'd0,
  parameter logic [31:0] StartCsrAddr  = 32'd16,
  parameter logic [31:0] StatusCsrAddr = 32'd17,
  parameter logic [31:0] BusyMask      = 32'h1,
  parameter int unsigned PollGap       = 4,
  parameter int unsigned MaxPolls      = 1024,
  localparam int unsigned IdxW  = (NumCfgCsr > 1) ? $clog2(NumCfgCsr) : 1,
  localparam int unsigned PollW = $clog2(MaxPolls + 1),
  localparam int unsigned GapW  = (PollGap > 1) ? $clog2(PollGap) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_wr_valid_i,
  output logic            cfg_wr_ready_o,
  input  logic [IdxW-1:0] cfg_wr_idx_i,
  input  logic [31:0]     cfg_wr_data_i,
  input  logic            launch_valid_i,
  output logic            launch_ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [31:0]     csr_req_bits_data_o,
  output logic [31:0]     csr_req_bits_addr_o,
  output logic            csr_req_bits_write_o,
  output logic            csr_req_valid_o,
  input  logic            csr_req_ready_i,
  input  logic            csr_rsp_valid_i,
  output logic            csr_rsp_ready_o,
  input  logic [31:0]     csr_rsp_bits_data_i
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_CFG   = 3'd1;
  localparam logic [2:0] WR_START = 3'd2;
  localparam logic [2:0] RD_REQ   = 3'd3;
  localparam logic [2:0] RD_RSP   = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]       state;
  logic [IdxW-1:0]  idx;
  logic [PollW-1:0] polls;
  logic [GapW-1:0]  gap;
  logic             error_q;
  logic [31:0]      shadow [NumCfgCsr];

  assign cfg_wr_ready_o = (state == IDLE);
  assign launch_ready_o = (state == IDLE);
  assign busy_o         = (state != IDLE) && (state != DONE);
  assign done_o         = (state == DONE);
  assign error_o        = error_q;

  // NOTE: every register here, the shadow bank included, uses non-blocking
  // assignments so that all state updates see the pre-edge values. The shadow
  // bank is reset explicitly because a reset must leave it all-zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      idx     <= '0;
      polls   <= '0;
      gap     <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < int'(NumCfgCsr); i++) begin
        shadow[i] <= '0;
      end
    end else begin
      // Writes only land in IDLE. A write in the same cycle as a launch lands
      // before WR_CFG first reads the bank. Indices past the bank are dropped.
      if (cfg_wr_valid_i && cfg_wr_ready_o && (32'(cfg_wr_idx_i) < NumCfgCsr)) begin
        shadow[cfg_wr_idx_i] <= cfg_wr_data_i;
      end

      case (state)
        IDLE: begin
          if (launch_valid_i) begin
            error_q <= 1'b0;
            idx     <= '0;
            state   <= WR_CFG;
          end
        end
        WR_CFG: begin
          if (csr_req_ready_i) begin
            if (idx == IdxW'(NumCfgCsr - 1)) begin
              state <= WR_START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        WR_START: begin
          if (csr_req_ready_i) begin
            polls <= '0;
            state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (csr_req_ready_i) begin
            // The counter saturates; it never wraps.
            if (polls != PollW'(MaxPolls)) begin
              polls <= polls + 1'b1;
            end
            state <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (csr_rsp_valid_i) begin
            if ((csr_rsp_bits_data_i & BusyMask) == '0) begin
              state <= DONE;
            end else if (polls == PollW'(MaxPolls)) begin
              error_q <= 1'b1;
              state   <= DONE;
            end else begin
              gap   <= '0;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap == GapW'(PollGap - 1)) begin
            state <= RD_REQ;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request outputs are a function of the registered state only. They stay
  // stable while the accelerator stalls because state and idx move only on
  // a handshake.
  // NOTE: every output is given a default first so that no path infers a latch.
  always_comb begin
    csr_req_valid_o      = 1'b0;
    csr_req_bits_write_o = 1'b0;
    csr_req_bits_addr_o  = '0;
    csr_req_bits_data_o  = '0;
    csr_rsp_ready_o      = 1'b0;
    case (state)
      WR_CFG: begin
        csr_req_valid_o      = 1'b1;
        csr_req_bits_write_o = 1'b1;
        csr_req_bits_addr_o  = CfgBaseAddr + 32'(idx);
        csr_req_bits_data_o  = shadow[idx];
      end
      WR_START: begin
        csr_req_valid_o      = 1'b1;
        csr_req_bits_write_o = 1'b1;
        csr_req_bits_addr_o  = StartCsrAddr;
        csr_req_bits_data_o  = 32'h1;
      end
      RD_REQ: begin
        csr_req_valid_o     = 1'b1;
        csr_req_bits_addr_o = StatusCsrAddr;
      end
      RD_RSP:  csr_rsp_ready_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snax_gemm_csr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snax_gemm_csr_sequencer
//
// Self-checking bench for snax_gemm_csr_sequencer. The DUT uses MaxPolls=3 so
// that timeouts are reachable quickly; all other parameters keep their defaults.
// Each launch is traced cycle by cycle: accepted requests, response cycles,
// read-request start cycles and done pulses. The trace is compared with the
// transaction list derived from a shadow-bank model and the polling rules.
// -----------------------------------------------------------------------------
module tb_snax_gemm_csr_sequencer;

  localparam int          NCFG    = 16;
  localparam int          MAXP    = 3;
  localparam int          PGAP    = 4;
  localparam logic [31:0] START_A = 32'd16;
  localparam logic [31:0] STAT_A  = 32'd17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_valid, cfg_wr_ready;
  logic [3:0]  cfg_wr_idx;
  logic [31:0] cfg_wr_data;
  logic        launch_valid, launch_ready;
  logic        busy, done, err_flag;
  logic [31:0] req_data, req_addr;
  logic        req_write, req_valid, csr_req_ready;
  logic        csr_rsp_valid, rsp_ready;
  logic [31:0] csr_rsp_data;

  always #5 clk = ~clk;

  snax_gemm_csr_sequencer #(.MaxPolls(MAXP)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cfg_wr_valid_i      (cfg_wr_valid),
    .cfg_wr_ready_o      (cfg_wr_ready),
    .cfg_wr_idx_i        (cfg_wr_idx),
    .cfg_wr_data_i       (cfg_wr_data),
    .launch_valid_i      (launch_valid),
    .launch_ready_o      (launch_ready),
    .busy_o              (busy),
    .done_o              (done),
    .error_o             (err_flag),
    .csr_req_bits_data_o (req_data),
    .csr_req_bits_addr_o (req_addr),
    .csr_req_bits_write_o(req_write),
    .csr_req_valid_o     (req_valid),
    .csr_req_ready_i     (csr_req_ready),
    .csr_rsp_valid_i     (csr_rsp_valid),
    .csr_rsp_ready_o     (rsp_ready),
    .csr_rsp_bits_data_i (csr_rsp_data)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // One table row = one launch: stimulus shape plus hand-derived results.
  // stall: 0 always ready, 1 ready on even cycles only, 2 random.
  typedef struct {
    int n_busy;
    int stall;
    bit noise;
    int exp_reads;
    bit exp_err;
    int exp_done;
  } vec_t;

  req_t        got_q[$];
  int          rsp_cyc_q[$];
  int          rd_first_q[$];
  int          done_q[$];
  logic [31:0] sh [NCFG];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_reads(input int n_busy);
    return (n_busy + 1 < MAXP) ? n_busy + 1 : MAXP;
  endfunction

  task automatic cfg_write(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    cfg_wr_valid = 1'b1;
    cfg_wr_idx   = idx;
    cfg_wr_data  = data;
    check("cfg_wr_ready_idle", 32'(cfg_wr_ready), 32'd1);
    sh[idx] = data;
    @(negedge clk);
    cfg_wr_valid = 1'b0;
  endtask

  task automatic run_launch(input int n_busy, input int stall, input bit noise,
                            input bit same_wr, input logic [3:0] sw_idx,
                            input logic [31:0] sw_data, input bit abort_rsp,
                            input int exp_reads, input bit exp_err, input int exp_done);
    req_t exp_q[$];
    req_t hold_r;
    bit   done_seen, in_rd, held, fin, aborted, wr_drv;
    int   done_cyc, rsp_n, cyc, quiet_bad;
    got_q.delete(); rsp_cyc_q.delete(); rd_first_q.delete(); done_q.delete();
    done_seen = 0; in_rd = 0; held = 0; fin = 0; aborted = 0;
    done_cyc = -1; rsp_n = 0; cyc = 0; hold_r = '0;

    @(negedge clk);
    launch_valid  = 1'b1;
    csr_req_ready = 1'b1;
    csr_rsp_valid = 1'b0;
    if (same_wr) begin
      cfg_wr_valid = 1'b1;
      cfg_wr_idx   = sw_idx;
      cfg_wr_data  = sw_data;
      sh[sw_idx]   = sw_data;
    end
    check("launch_ready", 32'(launch_ready), 32'd1);

    while (!fin && cyc < 400) begin
      wr_drv = 1'b0;
      if (cyc > 0) begin
        @(negedge clk);
        launch_valid  = 1'b0;
        cfg_wr_valid  = 1'b0;
        csr_rsp_valid = 1'b0;
        case (stall)
          0:       csr_req_ready = 1'b1;
          1:       csr_req_ready = ((cyc % 2) == 0);
          default: csr_req_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_ready) begin
          if (stall != 2 || $urandom_range(0, 2) != 0) begin
            csr_rsp_valid = 1'b1;
            csr_rsp_data  = (rsp_n < n_busy) ? ($urandom() | 32'h1) : ($urandom() & 32'hFFFF_FFFE);
          end
        end else if (noise) begin
          // A spurious idle-status response that must be ignored.
          csr_rsp_valid = 1'($urandom_range(0, 1));
          csr_rsp_data  = 32'h0;
        end
        if (noise && !done_seen) begin
          wr_drv       = 1'b1;
          cfg_wr_valid = 1'b1;
          cfg_wr_idx   = (cyc == 3) ? 4'd5 : 4'($urandom_range(0, 15));
          cfg_wr_data  = (cyc == 3) ? 32'hDEAD : $urandom();
        end
        if (abort_rsp && rsp_ready) begin
          rst_n         = 1'b0;
          csr_rsp_valid = 1'b1;
          csr_rsp_data  = 32'h0;
          aborted       = 1'b1;
          fin           = 1'b1;
        end
      end

      if (!aborted) begin
        if (cyc == 1) begin
          check("busy_after_launch", 32'(busy), 32'd1);
          check("error_cleared", 32'(err_flag), 32'd0);
        end
        if (wr_drv) check("cfg_wr_ready_busy", 32'(cfg_wr_ready), 32'd0);
        if (held) begin
          check("hold_valid", 32'(req_valid), 32'd1);
          check("hold_addr", req_addr, hold_r.addr);
          check("hold_data", req_data, hold_r.data);
          held = 1'b0;
        end
        if (req_valid) begin
          if (!req_write && !in_rd) begin
            rd_first_q.push_back(cyc);
            in_rd = 1'b1;
          end
          if (csr_req_ready) begin
            got_q.push_back('{req_write, req_addr, req_data});
            in_rd = 1'b0;
          end else begin
            held   = 1'b1;
            hold_r = '{req_write, req_addr, req_data};
          end
        end
        if (csr_rsp_valid && rsp_ready) begin
          rsp_cyc_q.push_back(cyc);
          rsp_n++;
        end
        if (done) begin
          done_q.push_back(cyc);
          if (!done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
            check("error_at_done", 32'(err_flag), 32'(exp_err));
          end
        end else if (done_seen) begin
          fin = 1'b1;
          check("busy_after_done", 32'(busy), 32'd0);
          check("launch_ready_after_done", 32'(launch_ready), 32'd1);
          check("error_sticky", 32'(err_flag), 32'(exp_err));
        end
      end
      cyc++;
    end
    csr_rsp_valid = 1'b0;
    cfg_wr_valid  = 1'b0;

    if (aborted) begin
      @(negedge clk);
      rst_n         = 1'b1;
      csr_rsp_valid = 1'b0;
      check("abort_valid", 32'(req_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rsp_ready", 32'(rsp_ready), 32'd0);
      check("abort_cfg_ready", 32'(cfg_wr_ready), 32'd1);
      quiet_bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (done || req_valid) quiet_bad++;
      end
      check("abort_quiet", 32'(quiet_bad), 32'd0);
      foreach (sh[i]) sh[i] = 32'h0;
      return;
    end

    check("done_within_budget", 32'(done_seen), 32'd1);
    for (int i = 0; i < NCFG; i++) exp_q.push_back('{1'b1, 32'(i), sh[i]});
    exp_q.push_back('{1'b1, START_A, 32'h1});
    repeat (exp_reads) exp_q.push_back('{1'b0, STAT_A, 32'h0});

    check("request_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("req%0d_write", i), 32'(got_q[i].write), 32'(exp_q[i].write));
      check($sformatf("req%0d_addr", i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("req%0d_data", i), got_q[i].data, exp_q[i].data);
    end
    check("done_pulses", 32'(done_q.size()), 32'd1);
    if (rsp_cyc_q.size() > 0) check("done_after_rsp", 32'(done_cyc), 32'(rsp_cyc_q[$] + 1));
    for (int j = 1; j < rd_first_q.size() && j <= rsp_cyc_q.size(); j++) begin
      check("poll_gap", 32'(rd_first_q[j] - rsp_cyc_q[j-1]), 32'(PGAP + 1));
    end
    if (exp_done >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   nb;
    tbl[0] = '{0, 0, 1'b0, 1, 1'b0, 20};
    tbl[1] = '{1, 0, 1'b0, 2, 1'b0, 26};
    tbl[2] = '{2, 0, 1'b0, 3, 1'b0, 32};
    tbl[3] = '{3, 0, 1'b0, 3, 1'b1, 32};
    tbl[4] = '{7, 0, 1'b0, 3, 1'b1, 32};
    tbl[5] = '{0, 1, 1'b0, 1, 1'b0, -1};
    tbl[6] = '{2, 1, 1'b1, 3, 1'b0, -1};

    rst_n = 1'b0; cfg_wr_valid = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
    launch_valid = 1'b0; csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rsp_data = '0;
    foreach (sh[i]) sh[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(err_flag), 32'd0);
    check("rst_cfg_ready", 32'(cfg_wr_ready), 32'd1);
    check("rst_launch_ready", 32'(launch_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < NCFG; i++) cfg_write(4'(i), 32'hA0 + 32'(i));

    for (int t = 0; t < 7; t++) begin
      run_launch(tbl[t].n_busy, tbl[t].stall, tbl[t].noise, 1'b0, 4'd0, 32'h0, 1'b0,
                 tbl[t].exp_reads, tbl[t].exp_err, tbl[t].exp_done);
    end

    // Same-cycle shadow write and launch: the write lands first.
    run_launch(0, 0, 1'b0, 1'b1, 4'd5, 32'hBEEF, 1'b0, 1, 1'b0, 20);
    if (got_q.size() > 5) check("beef_entry", got_q[5].data, 32'hBEEF);
    else                  check("beef_entry_present", 32'(got_q.size()), 32'd6);

    // Reset while waiting for a status response, then relaunch on a zero bank.
    run_launch(1, 0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 0, 1'b0, -1);
    run_launch(0, 0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1, 1'b0, 20);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 4)) cfg_write(4'($urandom_range(0, 15)), $urandom());
      nb = $urandom_range(0, 4);
      run_launch(nb, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom(), 1'b0,
                 model_reads(nb), (nb >= MAXP), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snax_gemm_csr_sequencer.md
Name: snax_gemm_csr_sequencer

Overview:
Hardware launcher for the streamer-GEMM accelerator. It holds a shadow bank of configuration CSR values and, on a launch command, drives the accelerator's simplified CSR request/response port with no core involvement. The sequence is: write every configuration CSR, write the start CSR, then poll the status CSR until the busy bits clear. It sits between the SNAX CSR translator output and the stream-GEMM CSR input, and frees the core during long GEMM runs.

Parameters:
NumCfgCsr, 16, number of configuration CSRs; shadow depth; must be >= 1
CfgBaseAddr, 0, CSR address of configuration entry 0; entry i is at CfgBaseAddr+i
StartCsrAddr, 16, address written with 32'h1 to start the accelerator
StatusCsrAddr, 17, address read to poll status
BusyMask, 32'h1, status bits that mean "busy"
PollGap, 4, idle cycles between status reads; must be >= 1
MaxPolls, 1024, status reads before timeout; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cfg_wr_valid_i  in  1  shadow write strobe
cfg_wr_ready_o  out  1  shadow write accepted
cfg_wr_idx_i  in  $clog2(NumCfgCsr)  shadow entry index
cfg_wr_data_i  in  32  shadow entry value
launch_valid_i  in  1  launch request
launch_ready_o  out  1  launch accepted
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle completion pulse
error_o  out  1  sticky timeout flag
csr_req_bits_data_o  out  32  CSR write data
csr_req_bits_addr_o  out  32  CSR address
csr_req_bits_write_o  out  1  1 = write, 0 = read
csr_req_valid_o  out  1  CSR request valid
csr_req_ready_i  in  1  CSR request ready
csr_rsp_valid_i  in  1  read response valid
csr_rsp_ready_o  out  1  read response ready
csr_rsp_bits_data_i  in  32  read response data

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is synchronous and active-low. It is sampled only on the rising edge of clk_i.
- Reset values:
  - state = IDLE; all shadow entries = 0.
  - counters = 0; error_o = 0; done_o = 0; busy_o = 0.
  - csr_req_valid_o = 0; csr_rsp_ready_o = 0.
  - cfg_wr_ready_o = 1; launch_ready_o = 1.
- Reset mid-sequence aborts immediately, with no further CSR traffic and no done_o. Shadow contents are also cleared.
- cfg_wr_ready_o = launch_ready_o = (state==IDLE). A shadow write completes on valid&&ready at the clock edge.
- If a cfg write and a launch happen in the same cycle, the write lands. The sequence then uses the updated value.
- Out-of-range cfg_wr_idx_i (>= NumCfgCsr) is accepted and dropped.
- CSR writes produce no response. Only reads produce exactly one response.
- Request outputs hold stable while csr_req_valid_o && !csr_req_ready_i.
- States and transitions:
  - IDLE: on launch_valid_i, clear error_o, set idx=0, go to WR_CFG.
  - WR_CFG: valid=1, write=1, addr=CfgBaseAddr+idx, data=shadow[idx]. On ready: if idx==NumCfgCsr-1 go to WR_START, else idx++.
  - WR_START: valid=1, write=1, addr=StartCsrAddr, data=32'h1. On ready: polls=0, go to RD_REQ.
  - RD_REQ: valid=1, write=0, addr=StatusCsrAddr, data=0. On ready: polls++, go to RD_RSP.
  - RD_RSP: csr_rsp_ready_o=1. On rsp_valid:
    - if (data & BusyMask)==0, go to DONE;
    - else if polls==MaxPolls, set error_o=1 and go to DONE;
    - else gap=0 and go to GAP.
  - GAP: count PollGap cycles, then go to RD_REQ.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- csr_rsp_ready_o=0 outside RD_RSP. Any response arriving outside RD_RSP is a protocol violation and is ignored.
- busy_o = (state != IDLE && state != DONE).
- The poll counter is $clog2(MaxPolls+1) bits wide and never wraps.
- Minimum latency, launch accepted at cycle 0 with always-ready and an immediately-idle status:
  - cfg writes on cycles 1..NumCfgCsr;
  - start write on NumCfgCsr+1;
  - status read request on NumCfgCsr+2;
  - response on NumCfgCsr+3 at the earliest;
  - done_o one cycle after the accepted response.

Test Plan:
- Shadow writes idx0..15 = 32'hA0+i, launch, ready=1, status=0 on the first read -> writes at addr 0..15 with data A0..AF in order, then addr16/data1, a read at 17, done_o at cycle 20, error_o=0.
- csr_req_ready_i toggles 1-0-1 on cfg writes -> address/data held while stalled, no duplicate or skipped entries, exactly 16 cfg writes total.
- Status returns 1, 1, 0 -> 3 reads at addr 17, with PollGap=4 idle cycles between response and the next request; done_o pulses once.
- MaxPolls=3, status always 1 -> exactly 3 reads, then error_o=1 and done_o. Next launch clears error_o.
- Cfg write idx5=32'hDEAD while busy -> cfg_wr_ready_o=0 and shadow unchanged. Same-cycle cfg write idx5=32'hBEEF with launch in IDLE -> entry 5 written as BEEF.
- rst_ni low during RD_RSP -> next cycle valid=0, busy_o=0, shadow=0, and no done_o.
